// File: rtl/obj_mem_pkg.sv
// Shared types and constants for the object-RAM sequencer: FSM states, block
// geometry and the partial-block validity mask helper.
package obj_mem_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RD_REQ,
    PRESENT,
    DONE
  } state_t;

  localparam int BLOCK_WORDS = 8;
  localparam int BLOCK_SHIFT = 3;

  // Low 'rem' bits set; rem == 0 means a completely full block.
  function automatic logic [BLOCK_WORDS-1:0] tail_mask(input logic [BLOCK_SHIFT-1:0] rem);
    logic [BLOCK_WORDS-1:0] m;
    m = '1;
    if (rem != '0) m = (BLOCK_WORDS'(1) << rem) - BLOCK_WORDS'(1);
    return m;
  endfunction

endpackage

// File: rtl/obj_mem_ctrl_word_counter.sv
// obj_word_counter: loaded-word count, load-limit compare and the per-block
// last/mask derivation used while blocks are presented.
module obj_word_counter
  import obj_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 6,
  parameter int LOAD_LIMIT = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   inc,
  input  logic [ADDR_WIDTH-4:0]  blk,
  output logic [ADDR_WIDTH-1:0]  wr_addr,
  output logic                   at_limit,
  output logic                   blk_last,
  output logic [BLOCK_WORDS-1:0] blk_mask
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] LIMIT_M1 = CW'(LOAD_LIMIT - 1);

  logic [CW-1:0] word_cnt;
  logic [CW-1:0] num_blk;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of its neighbours.
  always_ff @(posedge clk) begin
    if (rst)      word_cnt <= '0;
    else if (clr) word_cnt <= '0;
    else if (inc) word_cnt <= word_cnt + CW'(1);
  end

  // word_cnt + 7 cannot overflow CW bits because ADDR_WIDTH >= 3.
  assign num_blk  = (word_cnt + CW'(7)) >> BLOCK_SHIFT;
  assign wr_addr  = word_cnt[ADDR_WIDTH-1:0];
  assign at_limit = (word_cnt == LIMIT_M1);
  assign blk_last = (CW'(blk) == num_blk - CW'(1));
  assign blk_mask = blk_last ? tail_mask(word_cnt[BLOCK_SHIFT-1:0]) : '1;

endmodule

// File: rtl/obj_mem_ctrl.sv
// obj_mem_ctrl: loads a word burst into the object RAM, then presents it to the
// collision engine in 8-word blocks. Optional feature macro: OBJ_MEM_CTRL_REPLAY_EN.
module obj_mem_ctrl
  import obj_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6,
  parameter int LOAD_LIMIT = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   clear,
`ifdef OBJ_MEM_CTRL_REPLAY_EN
  input  logic                   replay,
`endif
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_WIDTH-1:0]  in_data,
  input  logic                   in_last,
  output logic                   ram_cs,
  output logic                   ram_we,
  output logic                   ram_oe,
  output logic [ADDR_WIDTH-1:0]  ram_addr_in,
  output logic [ADDR_WIDTH-1:0]  ram_addr_out,
  output logic [DATA_WIDTH-1:0]  ram_din,
  output logic                   blk_valid,
  input  logic                   blk_ready,
  output logic [ADDR_WIDTH-4:0]  blk_index,
  output logic                   blk_last,
  output logic [BLOCK_WORDS-1:0] blk_mask,
  output logic                   busy,
  output logic                   done,
  output logic                   err_trunc
);

  state_t                   state_q, state_d;
  logic [ADDR_WIDTH-4:0]    blk_q;
  logic                     err_q;
  logic                     load_start, blk_rst, blk_inc, word_inc;
  logic [ADDR_WIDTH-1:0]    wr_addr;
  logic                     at_limit, last_w;
  logic [BLOCK_WORDS-1:0]   mask_w;
  logic                     replay_req;

`ifdef OBJ_MEM_CTRL_REPLAY_EN
  assign replay_req = replay;
`else
  assign replay_req = 1'b0;
`endif

  obj_word_counter #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .LOAD_LIMIT (LOAD_LIMIT)
  ) u_word_counter (
    .clk      (clk),
    .rst      (rst),
    .clr      (load_start),
    .inc      (word_inc),
    .blk      (blk_q),
    .wr_addr  (wr_addr),
    .at_limit (at_limit),
    .blk_last (last_w),
    .blk_mask (mask_w)
  );

  // NOTE: RAM contents are outside this block and deliberately never reset;
  // only the sequencing registers return to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      blk_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (blk_rst)      blk_q <= '0;
      else if (blk_inc) blk_q <= blk_q + 1'b1;
      if (load_start)
        err_q <= 1'b0;
      else if (word_inc && !in_last && at_limit)
        err_q <= 1'b1;
    end
  end

  // NOTE: every output of this block gets a default first so no path through
  // the case statement can infer a latch.
  always_comb begin
    state_d      = state_q;
    in_ready     = 1'b0;
    ram_cs       = 1'b0;
    ram_we       = 1'b0;
    ram_oe       = 1'b0;
    ram_addr_in  = '0;
    ram_addr_out = '0;
    ram_din      = '0;
    blk_valid    = 1'b0;
    load_start   = 1'b0;
    word_inc     = 1'b0;
    blk_rst      = 1'b0;
    blk_inc      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = LOAD;
          load_start = 1'b1;
        end
      end
      LOAD: begin
        in_ready    = 1'b1;
        ram_cs      = in_valid;
        ram_we      = in_valid;
        ram_addr_in = wr_addr;
        ram_din     = in_data;
        word_inc    = in_valid;
        if (in_valid && (in_last || at_limit)) begin
          state_d = RD_REQ;
          blk_rst = 1'b1;
        end
      end
      RD_REQ: begin
        ram_cs       = 1'b1;
        ram_oe       = 1'b1;
        ram_addr_out = ADDR_WIDTH'(blk_q);
        state_d      = PRESENT;
      end
      PRESENT: begin
        // Keep the read active so the registered RAM outputs stay stable.
        ram_cs       = 1'b1;
        ram_oe       = 1'b1;
        ram_addr_out = ADDR_WIDTH'(blk_q);
        blk_valid    = 1'b1;
        if (blk_ready) begin
          if (last_w) begin
            state_d = DONE;
          end else begin
            blk_inc = 1'b1;
            state_d = RD_REQ;
          end
        end
      end
      DONE: begin
        if (clear) begin
          state_d = IDLE;
        end else if (replay_req) begin
          state_d = RD_REQ;
          blk_rst = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign blk_index = (state_q == PRESENT) ? blk_q : '0;
  assign blk_last  = (state_q == PRESENT) && last_w;
  assign blk_mask  = (state_q == PRESENT) ? mask_w : '0;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign err_trunc = err_q;

endmodule

// File: tb/tb_obj_mem_ctrl.sv
// Self-checking bench for obj_mem_ctrl: random word bursts against a word-list
// reference model and a behavioural RAM with registered 8-word reads.
module tb_obj_mem_ctrl;

  localparam int DW    = 32;
  localparam int AW    = 6;
  localparam int LIMIT = 32;

  logic          clk = 1'b0;
  logic          rst, start, clear, in_valid, in_ready, in_last;
  logic [DW-1:0] in_data;
  logic          ram_cs, ram_we, ram_oe;
  logic [AW-1:0] ram_addr_in, ram_addr_out;
  logic [DW-1:0] ram_din;
  logic          blk_valid, blk_ready, blk_last, busy, done, err_trunc;
  logic [AW-4:0] blk_index;
  logic [7:0]    blk_mask;
`ifdef OBJ_MEM_CTRL_REPLAY_EN
  logic          replay = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mem [64];
  logic [DW-1:0] rd_data [8];
  logic [DW-1:0] exp_words [64];
  int            exp_cnt;

  always #5 clk = ~clk;

  obj_mem_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LOAD_LIMIT(LIMIT)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .clear        (clear),
`ifdef OBJ_MEM_CTRL_REPLAY_EN
    .replay       (replay),
`endif
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_last      (in_last),
    .ram_cs       (ram_cs),
    .ram_we       (ram_we),
    .ram_oe       (ram_oe),
    .ram_addr_in  (ram_addr_in),
    .ram_addr_out (ram_addr_out),
    .ram_din      (ram_din),
    .blk_valid    (blk_valid),
    .blk_ready    (blk_ready),
    .blk_index    (blk_index),
    .blk_last     (blk_last),
    .blk_mask     (blk_mask),
    .busy         (busy),
    .done         (done),
    .err_trunc    (err_trunc)
  );

  // Behavioural object RAM: synchronous write, registered 8-word block read.
  always @(posedge clk) begin
    if (ram_cs && ram_we) mem[ram_addr_in] <= ram_din;
    if (ram_cs && ram_oe && !ram_we)
      for (int i = 0; i < 8; i++) rd_data[i] <= mem[int'(ram_addr_out) * 8 + i];
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge in IDLE; returns just after the negedge of RD_REQ.
  task automatic do_load(input int n_words, input int last_pos);
    int  sent, cyc, exp_n;
    bit  trunc;
    trunc = !(last_pos != 0 && last_pos <= LIMIT);
    exp_n = trunc ? LIMIT : last_pos;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("load_busy", busy, 1);
    check("load_err_cleared", err_trunc, 0);
    sent = 0;
    cyc  = 0;
    while (sent < exp_n && cyc < 1000) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_data  = $urandom;
      in_last  = (sent + 1 == last_pos);
      #1;
      if (in_valid) begin
        check("load_ready", in_ready, 1);
        check("load_ctrl", {ram_cs, ram_we, ram_oe}, 3'b110);
        check("load_addr", ram_addr_in, sent);
        check("load_din", ram_din, in_data);
        exp_words[sent] = in_data;
        sent++;
      end
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 1000) check("load_timeout", sent, exp_n);
    in_last  = 1'b0;
    in_valid = (n_words > exp_n);
    in_data  = $urandom;
    #1;
    check("post_load_ready", in_ready, 0);
    check("rdreq_ctrl", {ram_cs, ram_we, ram_oe}, 3'b101);
    check("err_trunc", err_trunc, trunc);
    in_valid = 1'b0;
    exp_cnt  = exp_n;
  endtask

  // Receives every block; stalls block 0 for 'stall' cycles; returns while
  // presenting block 'stop_at' (use -1 to run to DONE).
  task automatic rx_blocks(input int stall, input int stop_at);
    int         nblk, waits, rem;
    logic [7:0] m;
    logic [63:0] snap;
    logic [DW-1:0] snap_rd [8];
    bit         same;
    nblk = (exp_cnt + 7) / 8;
    for (int b = 0; b < nblk; b++) begin
      waits = 0;
      while (!blk_valid && waits < 20) begin
        @(negedge clk);
        waits++;
      end
      check("blk_latency", waits, 1);
      rem = exp_cnt - 8 * b;
      m   = (rem >= 8) ? 8'hFF : (8'hFF >> (8 - rem));
      check("blk_index", blk_index, b);
      check("blk_last", blk_last, (b == nblk - 1));
      check("blk_mask", blk_mask, m);
      check("blk_addr_out", ram_addr_out, b);
      check("blk_ctrl", {ram_cs, ram_we, ram_oe}, 3'b101);
      for (int i = 0; i < 8; i++)
        if (m[i]) check("blk_data", rd_data[i], exp_words[8 * b + i]);
      if (b == stop_at) return;
      if (b == 0 && stall > 0) begin
        blk_ready = 1'b0;
        snap = {blk_valid, blk_index, blk_mask, blk_last, ram_addr_out, ram_cs, ram_oe};
        for (int i = 0; i < 8; i++) snap_rd[i] = rd_data[i];
        repeat (stall) begin
          @(negedge clk);
          check("stall_ctrl",
                {blk_valid, blk_index, blk_mask, blk_last, ram_addr_out, ram_cs, ram_oe}, snap);
          same = 1'b1;
          for (int i = 0; i < 8; i++) if (rd_data[i] !== snap_rd[i]) same = 1'b0;
          check("stall_rd_data", same, 1);
        end
        blk_ready = 1'b1;
      end
      @(negedge clk);
    end
    check("done", {done, busy, blk_valid}, 3'b110);
    check("done_ctrl", {ram_cs, ram_we, ram_oe}, 3'b000);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("clear_idle", {busy, done}, 2'b00);
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, {in_ready, ram_cs, ram_we, ram_oe, ram_addr_in, ram_addr_out, ram_din,
                blk_valid, blk_index, blk_last, blk_mask, busy, done, err_trunc}, '0);
  endtask

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; clear = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    in_data = '1; blk_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_all_zero("reset_state");
    rst = 1'b0;
    @(negedge clk);

    // 16 words, in_last on word 16: two full blocks.
    do_load(16, 16);
    rx_blocks(0, -1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_ignored_in_done", done, 1);
    clear = 1'b1; start = 1'b1;
    @(negedge clk);
    clear = 1'b0; start = 1'b0;
    check("clear_beats_start", busy, 0);
    @(negedge clk);
    check("start_dropped", busy, 0);

    // 11 words: partial last block with mask 07.
    do_load(11, 11);
    rx_blocks(0, -1);
    do_clear();

    // 40 words, no in_last: truncated at LOAD_LIMIT.
    do_load(40, 0);
    rx_blocks(0, -1);
    check("err_sticky_done", err_trunc, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_all_zero("reset_from_done");

    // blk_ready held low 5 cycles on block 0.
    do_load(20, 20);
    rx_blocks(5, -1);
    do_clear();

    // Reset during PRESENT of block 1, then a clean reload.
    do_load(16, 16);
    rx_blocks(0, 1);
    rst = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    check_all_zero("reset_mid_present");
    rst = 1'b0;
    in_valid = 1'b0;
    do_load(5, 5);
    rx_blocks(0, -1);
    do_clear();

    // Random-length bursts.
    repeat (3) begin
      n = $urandom_range(1, LIMIT);
      do_load(n, n);
      rx_blocks($urandom_range(0, 3), -1);
      do_clear();
    end

`ifdef OBJ_MEM_CTRL_REPLAY_EN
    do_load(8, 8);
    rx_blocks(0, -1);
    replay = 1'b1;
    @(negedge clk);
    replay = 1'b0;
    rx_blocks(2, -1);
    replay = 1'b1; clear = 1'b1;
    @(negedge clk);
    replay = 1'b0; clear = 1'b0;
    check("clear_beats_replay", {busy, done}, 2'b00);
`else
    do_load(8, 8);
    rx_blocks(0, -1);
    do_clear();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/obj_mem_ctrl.md
# obj_mem_ctrl

Sequencer for the 32-bit object RAM in the collision-detection datapath. It loads a burst of object words from an upstream valid/ready stream into the RAM one word per cycle. It then reads the RAM back in 8-word blocks and hands each block to the collision engine over a valid/ready handshake, with a per-word validity mask for a partial final block. The RAM's eight read outputs go straight to the engine; this block only drives the RAM control, addresses and handshakes.

## Interface
- DATA_WIDTH, 32, object word width.
- ADDR_WIDTH, 6, RAM word-address width; must be ≥ 3.
- LOAD_LIMIT, 32, maximum words per load; 1 ≤ LOAD_LIMIT ≤ 2^ADDR_WIDTH.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  pulse: begin a load (honoured in IDLE only).
- clear  in  1  pulse: leave DONE for IDLE.
- in_valid / in_ready  in / out  1  upstream word handshake.
- in_data  in  DATA_WIDTH  object word.
- in_last  in  1  marks final word of the load.
- ram_cs, ram_we, ram_oe  out  1  RAM chip select, write enable, output enable.
- ram_addr_in  out  ADDR_WIDTH  RAM write word address.
- ram_addr_out  out  ADDR_WIDTH  RAM read block index; the RAM reads words index*8 … index*8+7.
- ram_din  out  DATA_WIDTH  RAM write data.
- blk_valid / blk_ready  out / in  1  block handshake to the collision engine.
- blk_index  out  ADDR_WIDTH-3  index of the presented block.
- blk_last  out  1  presented block is the final one.
- blk_mask  out  8  bit i set means RAM output i holds a loaded word.
- busy  out  1  state ≠ IDLE.
- done  out  1  state == DONE.
- err_trunc  out  1  sticky: the load ended at LOAD_LIMIT without in_last.

## Operation
- States: IDLE, LOAD, RD_REQ, PRESENT, DONE.
- IDLE → LOAD on start.
  - word_cnt := 0.
  - err_trunc cleared.
- LOAD
  - in_ready = 1.
  - ram_cs = ram_we = in_valid.
  - ram_addr_in = word_cnt; ram_din = in_data, combinationally.
  - On each accepted word (in_valid && in_ready): word_cnt++.
  - Go to RD_REQ with blk := 0 when the accepted word has in_last, or when word_cnt+1 == LOAD_LIMIT.
  - If the limit is hit without in_last: set err_trunc; later upstream words stall (in_ready = 0).
- RD_REQ
  - ram_cs = 1, ram_we = 0, ram_oe = 1, ram_addr_out = blk.
  - Unconditionally → PRESENT next cycle (RAM has registered read).
- PRESENT
  - Hold the RD_REQ RAM controls and address, so the RAM outputs stay driven and stable.
  - blk_valid = 1.
  - On blk_valid && blk_ready:
    - → DONE if blk_last.
    - Otherwise blk++ and → RD_REQ.
- DONE
  - RAM controls idle, RAM contents retained.
  - → IDLE on clear.
- Arithmetic
  - word_cnt is ADDR_WIDTH+1 bits.
  - num_blk = (word_cnt + 7) >> 3.
  - blk_last = (blk == num_blk - 1).
  - blk_mask = 8'hFF unless blk_last; if blk_last, the low (word_cnt mod 8) bits are set, or 8'hFF when word_cnt mod 8 == 0.
- Ignored inputs
  - start outside IDLE is ignored.
  - clear outside DONE is ignored.
  - clear and start in the same cycle in DONE: clear wins, start is dropped.
- Reset (any state, including mid-load or mid-present)
  - State → IDLE; word_cnt and blk → 0.
  - All outputs 0, err_trunc included.
  - RAM contents not cleared.
- ram_cs, ram_we and ram_oe are 0 in IDLE and DONE.
- ram_we is never 1 while ram_oe is 1.

## Timing
- Write: a word accepted in cycle n is in the RAM after edge n+1.
- Load to first block: the cycle after the final accepted word is RD_REQ. blk_valid rises the following cycle (2 cycles after the last accept).
- Block to block: minimum 2 cycles per block (RD_REQ + PRESENT).
- blk_valid stays high until accepted. blk_index, blk_mask and blk_last are stable while blk_valid is high.
- in_ready and blk_valid do not depend combinationally on in_valid or blk_ready.

## Configuration
- OBJ_MEM_CTRL_REPLAY_EN
  - Defined: adds input port replay. A replay pulse in DONE → RD_REQ with blk := 0, re-presenting all blocks from retained RAM without reloading. replay and clear in the same cycle: clear wins.
  - Undefined: no replay port; DONE exits only via clear.

## Structure
- Shared package obj_mem_pkg:
  - state enum.
  - BLOCK_WORDS = 8, BLOCK_SHIFT = 3.
  - Mask-generation function.
- One natural sub-module: obj_word_counter, which holds word_cnt, the limit compare and the num_blk/blk_last/blk_mask derivation.
- The RAM is instantiated by the parent, not inside this block.

## Test plan
- 16 words, in_last on word 16, blk_ready tied 1:
  - addresses 0–15 written in order.
  - 2 blocks presented: indices 0 and 1, blk_mask FF both, blk_last on index 1.
  - done asserts.
- 11 words:
  - 2 blocks.
  - Block 1 has blk_mask 8'h07 and blk_last = 1.
- 40 words with no in_last, LOAD_LIMIT = 32:
  - in_ready drops after word 32.
  - err_trunc = 1.
  - 4 blocks presented.
- blk_ready held low 5 cycles on block 0:
  - blk_valid, blk_index, blk_mask and the RAM outputs are stable throughout.
  - Advance occurs only on the handshake.
- rst asserted during PRESENT of block 1:
  - next cycle all outputs 0, state IDLE.
  - A new start then loads cleanly from address 0.
- With OBJ_MEM_CTRL_REPLAY_EN, 8 words loaded then replay in DONE:
  - block 0 is re-presented with identical data.
  - Without the macro, clear returns to IDLE.
